// File: rtl/inst_ram_load_ctrl.sv
// Boot-time loader for the byte-wide instruction RAM; hands the port to fetch when done.
// Optional running checksum of written bytes: define LOAD_CSUM_EN.
module inst_ram_load_ctrl #(
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 256,
  parameter int CNT_W  = 9
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              ld_valid,
  input  logic [31:0]       ld_data,
  input  logic              ld_last,
  output logic              ld_ready,
  input  logic              load_req,
  input  logic [ADDR_W-1:0] cpu_addr,
  output logic              cpu_run,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [7:0]        ram_wdata,
  output logic              ram_we,
  output logic [CNT_W-1:0]  byte_count,
  output logic              ld_ovf,
  output logic [7:0]        ld_csum
);

  typedef enum logic [1:0] {
    ACCEPT = 2'd0,
    WRITE  = 2'd1,
    RUN    = 2'd2
  } state_t;

  localparam logic [ADDR_W-1:0] PTR_MAX = ADDR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(DEPTH);

  state_t              state, state_n;
  logic [ADDR_W-1:0]   ptr, ptr_n;
  logic [1:0]          idx, idx_n;
  logic [31:0]         word, word_n;
  logic                last, last_n;
  logic                run_q, run_n;
  logic                we_q, we_n;
  logic [7:0]          wd_q, wd_n;
  logic [CNT_W-1:0]    cnt_q, cnt_n;
  logic                ovf_q, ovf_n;
  logic [31:0]         shifted;

`ifdef LOAD_CSUM_EN
  logic [7:0]          csum_q, csum_n;
`endif

  // Byte for the next write cycle, MSB first.
  always_comb begin
    shifted = word << {idx + 2'd1, 3'b000};
  end

  always_comb begin
    state_n = state;
    ptr_n   = ptr;
    idx_n   = idx;
    word_n  = word;
    last_n  = last;
    run_n   = 1'b0;
    we_n    = 1'b0;
    wd_n    = wd_q;
    cnt_n   = cnt_q;
    ovf_n   = ovf_q;
`ifdef LOAD_CSUM_EN
    csum_n  = csum_q;
`endif
    unique case (state)
      ACCEPT: begin
        if (ld_valid) begin
          word_n  = ld_data;
          last_n  = ld_last;
          idx_n   = 2'd0;
          state_n = WRITE;
          we_n    = 1'b1;
          wd_n    = ld_data[31:24];
        end
      end
      WRITE: begin
        if (ptr == PTR_MAX) begin
          ptr_n = '0;
          ovf_n = 1'b1;
        end else begin
          ptr_n = ptr + 1'b1;
        end
        if (cnt_q != CNT_MAX) cnt_n = cnt_q + 1'b1;
`ifdef LOAD_CSUM_EN
        csum_n = csum_q + wd_q;
`endif
        idx_n = idx + 2'd1;
        if (idx == 2'd3) begin
          state_n = last ? RUN : ACCEPT;
          run_n   = last;
        end else begin
          we_n = 1'b1;
          wd_n = shifted[31:24];
        end
      end
      RUN: begin
        run_n = 1'b1;
        if (load_req) begin
          state_n = ACCEPT;
          run_n   = 1'b0;
          ptr_n   = '0;
          cnt_n   = '0;
          ovf_n   = 1'b0;
`ifdef LOAD_CSUM_EN
          csum_n  = 8'h00;
`endif
        end
      end
      default: begin
        state_n = ACCEPT;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state <= ACCEPT;
      ptr   <= '0;
      idx   <= 2'd0;
      word  <= 32'h0;
      last  <= 1'b0;
      run_q <= 1'b0;
      we_q  <= 1'b0;
      wd_q  <= 8'h00;
      cnt_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      state <= state_n;
      ptr   <= ptr_n;
      idx   <= idx_n;
      word  <= word_n;
      last  <= last_n;
      run_q <= run_n;
      we_q  <= we_n;
      wd_q  <= wd_n;
      cnt_q <= cnt_n;
      ovf_q <= ovf_n;
    end
  end

`ifdef LOAD_CSUM_EN
  always_ff @(posedge clk) begin
    if (!reset_n) csum_q <= 8'h00;
    else          csum_q <= csum_n;
  end
  assign ld_csum = csum_q;
`else
  assign ld_csum = 8'h00;
`endif

  assign ld_ready   = (state == ACCEPT);
  assign ram_addr   = (state == RUN) ? cpu_addr : ptr;
  assign cpu_run    = run_q;
  assign ram_we     = we_q;
  assign ram_wdata  = wd_q;
  assign byte_count = cnt_q;
  assign ld_ovf     = ovf_q;

endmodule

// File: tb/tb_inst_ram_load_ctrl.sv
// Directed bench for inst_ram_load_ctrl.
// Checks reset, word split order, run mux, wrap/overflow, reload and checksum.
module tb_inst_ram_load_ctrl;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        ld_valid;
  logic [31:0] ld_data;
  logic        ld_last;
  logic        ld_ready;
  logic        load_req;
  logic [7:0]  cpu_addr;
  logic        cpu_run;
  logic [7:0]  ram_addr;
  logic [7:0]  ram_wdata;
  logic        ram_we;
  logic [8:0]  byte_count;
  logic        ld_ovf;
  logic [7:0]  ld_csum;

  logic [7:0]  mem [256];
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  inst_ram_load_ctrl #(.ADDR_W(8), .DEPTH(256), .CNT_W(9)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .ld_valid   (ld_valid),
    .ld_data    (ld_data),
    .ld_last    (ld_last),
    .ld_ready   (ld_ready),
    .load_req   (load_req),
    .cpu_addr   (cpu_addr),
    .cpu_run    (cpu_run),
    .ram_addr   (ram_addr),
    .ram_wdata  (ram_wdata),
    .ram_we     (ram_we),
    .byte_count (byte_count),
    .ld_ovf     (ld_ovf),
    .ld_csum    (ld_csum)
  );

  // Behavioural stand-in for the async-read, sync-write RAM.
  always @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_wdata;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic load_word(input logic [31:0] d, input logic l);
    ld_valid = 1'b1;
    ld_data  = d;
    ld_last  = l;
    tick();
    ld_valid = 1'b0;
    ld_last  = 1'b0;
    repeat (4) tick();
  endtask

  initial begin
    reset_n  = 1'b0;
    ld_valid = 1'b0;
    ld_data  = 32'h0;
    ld_last  = 1'b0;
    load_req = 1'b0;
    cpu_addr = 8'h00;
    repeat (2) tick();

    check("rst_run",   32'(cpu_run),    32'h0);
    check("rst_we",    32'(ram_we),     32'h0);
    check("rst_ready", 32'(ld_ready),   32'h1);
    check("rst_cnt",   32'(byte_count), 32'h0);
    check("rst_ovf",   32'(ld_ovf),     32'h0);
    check("rst_csum",  32'(ld_csum),    32'h0);
    check("rst_wd",    32'(ram_wdata),  32'h0);

    // One-word image
    reset_n  = 1'b1;
    ld_valid = 1'b1;
    ld_data  = 32'hE3A0_1005;
    ld_last  = 1'b1;
    tick();
    ld_valid = 1'b0;
    ld_last  = 1'b0;
    check("w0_ready", 32'(ld_ready),  32'h0);
    check("w0_we",    32'(ram_we),    32'h1);
    check("w0_addr",  32'(ram_addr),  32'h0);
    check("w0_data",  32'(ram_wdata), 32'hE3);
    tick();
    check("w1_addr",  32'(ram_addr),  32'h1);
    check("w1_data",  32'(ram_wdata), 32'hA0);
    tick();
    check("w2_addr",  32'(ram_addr),  32'h2);
    check("w2_data",  32'(ram_wdata), 32'h10);
    tick();
    check("w3_addr",  32'(ram_addr),  32'h3);
    check("w3_data",  32'(ram_wdata), 32'h05);
    check("w3_run",   32'(cpu_run),   32'h0);
    tick();
    check("t2_run",   32'(cpu_run),    32'h1);
    check("t2_we",    32'(ram_we),     32'h0);
    check("t2_cnt",   32'(byte_count), 32'h4);
    check("t2_mem",   {mem[0], mem[1], mem[2], mem[3]}, 32'hE3A0_1005);

    // Run-mode address mux
    cpu_addr = 8'h04;
    #1;
    check("mux_04", 32'(ram_addr), 32'h04);
    cpu_addr = 8'h08;
    #1;
    check("mux_08", 32'(ram_addr), 32'h08);
    ld_valid = 1'b1;
    ld_data  = 32'hDEAD_BEEF;
    #1;
    check("run_ready", 32'(ld_ready), 32'h0);
    tick();
    check("run_we",   32'(ram_we),     32'h0);
    check("run_hold", 32'(cpu_run),    32'h1);
    check("run_cnt",  32'(byte_count), 32'h4);
    ld_valid = 1'b0;

    // Reload
    load_req = 1'b1;
    tick();
    load_req = 1'b0;
    check("rl_run",   32'(cpu_run),    32'h0);
    check("rl_ready", 32'(ld_ready),   32'h1);
    check("rl_ptr",   32'(ram_addr),   32'h0);
    check("rl_cnt",   32'(byte_count), 32'h0);

    // Overflow: 65 words into 256 bytes
    for (int k = 1; k <= 63; k++)
      load_word({8'(k), 8'(k + 1), 8'(k + 2), 8'(k + 3)}, 1'b0);
    check("ov63_ovf", 32'(ld_ovf),     32'h0);
    check("ov63_cnt", 32'(byte_count), 32'd252);
    load_word({8'd64, 8'd65, 8'd66, 8'd67}, 1'b0);
    check("ov64_cnt", 32'(byte_count), 32'd256);
    check("ov64_ptr", 32'(ram_addr),   32'h0);
    load_word(32'h1122_3344, 1'b1);
    check("ov_ovf",  32'(ld_ovf),     32'h1);
    check("ov_cnt",  32'(byte_count), 32'd256);
    check("ov_run",  32'(cpu_run),    32'h1);
    check("ov_mem0", {mem[0], mem[1], mem[2], mem[3]}, 32'h1122_3344);
    check("ov_mem4", 32'(mem[4]),   32'h02);
    check("ov_mem255", 32'(mem[255]), 32'd67);

    // Checksum image
    load_req = 1'b1;
    tick();
    load_req = 1'b0;
    check("rl2_ovf", 32'(ld_ovf), 32'h0);
    load_word(32'h0102_0304, 1'b0);
    load_word(32'hFFFF_FFFF, 1'b1);
    check("cs_run", 32'(cpu_run),    32'h1);
    check("cs_cnt", 32'(byte_count), 32'h8);
`ifdef LOAD_CSUM_EN
    check("cs_sum", 32'(ld_csum), 32'h06);
`else
    check("cs_sum", 32'(ld_csum), 32'h00);
`endif

    // Reset in the middle of a word
    load_req = 1'b1;
    tick();
    load_req = 1'b0;
    ld_valid = 1'b1;
    ld_data  = 32'hAABB_CCDD;
    ld_last  = 1'b1;
    tick();
    ld_valid = 1'b0;
    ld_last  = 1'b0;
    tick();
    check("mid_we",  32'(ram_we),    32'h1);
    check("mid_wd",  32'(ram_wdata), 32'hBB);
    reset_n = 1'b0;
    tick();
    check("mr_we",    32'(ram_we),     32'h0);
    check("mr_ready", 32'(ld_ready),   32'h1);
    check("mr_run",   32'(cpu_run),    32'h0);
    check("mr_cnt",   32'(byte_count), 32'h0);
    check("mr_addr",  32'(ram_addr),   32'h0);
    reset_n = 1'b1;
    tick();
    check("mr_idle_we", 32'(ram_we), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
